// File: rtl/cas_div_seq_ctrl.sv
// cas_div_seq_ctrl: sequences one shared CAS add/subtract step over four cycles for a 7-by-4-bit non-restoring divide
module cas_div_seq_ctrl #(
  parameter logic       FIRST_SUB = 1'b1,
  parameter logic [3:0] ERR_Q     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] d_in,
  input  logic [3:0] m_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       dz,
  output logic       ovf,
  output logic       step_q,
  output logic [1:0] step_idx
);
  typedef enum logic [1:0] {IDLE, STEP, FIX, ERR} state_t;
  state_t state, state_nxt;
  logic [6:0] d_r;
  logic [3:0] m_r, qb, rem;
  logic [5:0] p, t, p_nxt, m6;
  logic [1:0] cnt;
  logic       accept, bad;
  generate
    if (FIRST_SUB != 1'b1) begin : g_first_sub
      $error("cas_div_seq_ctrl: only FIRST_SUB = 1 is supported");
    end
  endgenerate
  assign m6     = {2'b00, m_r};
  assign accept = state == IDLE && start;
  // a quotient above 15 exists exactly when the top three dividend bits reach M
  assign bad    = m_in == 4'd0 || {1'b0, d_in[6:4]} >= m_in;
  assign t      = {p[4:0], d_r[{1'b0, ~cnt}]};
  assign p_nxt  = cnt == 2'd0 ? {2'b00, d_r[6:3]} - m6 : p[5] ? t + m6 : t - m6;
  assign rem    = p[5] ? p[3:0] + m_r : p[3:0];
  assign busy   = state != IDLE;
  always_comb begin
    state_nxt = state == IDLE ? (start ? (bad ? ERR : STEP) : IDLE) :
                state == STEP ? (cnt == 2'd3 ? FIX : STEP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r      <= '0;
      m_r      <= '0;
      p        <= '0;
      cnt      <= '0;
      qb       <= '0;
      q        <= '0;
      r        <= '0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      step_q   <= 1'b0;
      step_idx <= '0;
    end else begin
      done <= state == FIX || state == ERR;
      if (accept) begin
        d_r <= d_in;
        m_r <= m_in;
        cnt <= '0;
        dz  <= m_in == 4'd0;
        ovf <= m_in != 4'd0 && bad;
      end
      if (state == STEP) begin
        p        <= p_nxt;
        qb[~cnt] <= ~p_nxt[5];
        step_q   <= ~p_nxt[5];
        step_idx <= cnt;
        cnt      <= cnt + 2'd1;
      end
      if (state == FIX) begin
        q <= qb;
        r <= rem;
      end
      if (state == ERR) begin
        q <= ERR_Q;
        r <= '0;
      end
    end
  end
endmodule
